// File: rtl/aig_response_collector_if.sv
// Response-word handshake between the circuit-under-test reader and the collector.
// The producer drives valid/data and the collector drives ready.
interface aig_response_collector_if #(
  parameter int OUT_W = 18
);
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/aig_response_collector.sv
// Response collector for CCGRCG50: duplicated-group consistency check plus MISR compaction.
// Optional watchdog enabled by defining COLLECTOR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start, in_ready low
// RUN   | accepting response words, busy high
// DONE  | results held until the next start
module aig_response_collector #(
  parameter int               OUT_W       = 18,
  parameter int               SIG_W       = 32,
  parameter int               CNT_W       = 16,
  parameter logic [SIG_W-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SIG_SEED    = 32'hFFFFFFFF,
  parameter logic [OUT_W-1:0] MASK_A      = 18'h0687F,
  parameter logic [OUT_W-1:0] MASK_B      = 18'h39780,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_vectors,
  aig_response_collector_if.slave       bus,
  output logic                          busy,
  output logic                          done,
  output logic [SIG_W-1:0]              sig_out,
  output logic [CNT_W-1:0]              mismatch_cnt,
  output logic                          group_err,
  output logic [CNT_W-1:0]              first_err_idx,
  output logic                          timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] num_lat;
  logic             accept;
  logic             last_word;
  logic             word_bad;
  logic [OUT_W-1:0] masked_a;
  logic [OUT_W-1:0] masked_b;
  logic [SIG_W-1:0] sig_next;

  assign bus.in_ready = (state == RUN);
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_word    = (vec_cnt == num_lat - CNT_W'(1));

  // A group is healthy only when all its duplicated outputs agree.
  assign masked_a = bus.in_data & MASK_A;
  assign masked_b = bus.in_data & MASK_B;
  assign word_bad = ((masked_a != '0) && (masked_a != MASK_A)) ||
                    ((masked_b != '0) && (masked_b != MASK_B));

  assign sig_next = {sig_out[SIG_W-2:0], 1'b0} ^ (sig_out[SIG_W-1] ? POLY : '0) ^
                    SIG_W'(bus.in_data);

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sig_out       <= SIG_SEED;
      vec_cnt       <= '0;
      num_lat       <= '0;
      mismatch_cnt  <= '0;
      group_err     <= 1'b0;
      first_err_idx <= '0;
`ifdef COLLECTOR_TIMEOUT_EN
      timeout       <= 1'b0;
      wd_cnt        <= WD_LOAD;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig_out       <= SIG_SEED;
            vec_cnt       <= '0;
            mismatch_cnt  <= '0;
            group_err     <= 1'b0;
            first_err_idx <= '0;
            num_lat       <= num_vectors;
            state         <= (num_vectors != '0) ? RUN : DONE;
`ifdef COLLECTOR_TIMEOUT_EN
            timeout       <= 1'b0;
            wd_cnt        <= WD_LOAD;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            sig_out <= sig_next;
            vec_cnt <= vec_cnt + CNT_W'(1);
            if (word_bad) begin
              if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
              if (!group_err) first_err_idx <= vec_cnt;
              group_err <= 1'b1;
            end
            if (last_word) state <= DONE;
`ifdef COLLECTOR_TIMEOUT_EN
            wd_cnt <= WD_LOAD;
`endif
          end
`ifdef COLLECTOR_TIMEOUT_EN
          // Down-counter terminal count: TIMEOUT_CYC idle cycles since the last accept.
          else if (wd_cnt == '0) begin
            state   <= DONE;
            timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aig_response_collector.md
Name: aig_response_collector

Overview:
- Output-side reader for the CCGRCG50 benchmark circuit (12 inputs, 18 outputs).
- Accepts 18-bit response words from the circuit-under-test through a valid/ready handshake.
- Checks that each duplicated output group is internally consistent.
- Compacts every accepted word into a MISR signature and reports done, signature and error statistics to the test controller.

Parameters:
- OUT_W, 18, response word width (outputs f1..f18 map to bits 0..17).
- SIG_W, 32, MISR width.
- CNT_W, 16, width of the vector, mismatch and index counters.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SIG_SEED, 32'hFFFFFFFF, MISR value loaded at start.
- MASK_A, 18'h0687F, bits that must all be equal (f1..f7, f12, f14, f15).
- MASK_B, 18'h39780, bits that must all be equal (f8..f11, f13, f16..f18).
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a collection run.
- num_vectors  in  CNT_W  number of words to accept; sampled on start.
- in_valid  in  1  response word valid.
- in_ready  out  1  collector can accept a word.
- in_data  in  OUT_W  response word.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- sig_out  out  SIG_W  current MISR value.
- mismatch_cnt  out  CNT_W  count of inconsistent words, saturating.
- group_err  out  1  sticky; set on any inconsistent word.
- first_err_idx  out  CNT_W  index of the first inconsistent word.
- timeout  out  1  watchdog expired; tied to 0 when the feature is absent.

Behaviour:
- Reset values:
  - State IDLE; in_ready=0, busy=0, done=0, timeout=0, group_err=0.
  - sig_out=SIG_SEED; mismatch_cnt=0; first_err_idx=0; vec_cnt=0.
- States and transitions: IDLE, RUN, DONE.
  - IDLE: in_ready=0. On start:
    - num_vectors!=0: load sig=SIG_SEED; clear vec_cnt, mismatch_cnt, group_err, first_err_idx, timeout; latch num_vectors; go to RUN.
    - num_vectors==0: perform the same clears, then go directly to DONE; sig_out stays SIG_SEED.
  - RUN: in_ready=1 and busy=1, both combinational from state. A word is accepted when in_valid&in_ready.
    - On the accept with vec_cnt==num_vectors-1, go to DONE on the next edge. in_ready is low from that next cycle.
    - start is ignored while in RUN.
  - DONE: done=1. All results hold until start.
    - start in DONE restarts, applying the same rules as start in IDLE.
- Per accepted word (results registered, visible the cycle after the accept):
  - MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended in_data.
  - Consistency check: group A is consistent iff (in_data&MASK_A) equals 0 or MASK_A; group B is checked the same way with MASK_B.
  - If either group is inconsistent:
    - mismatch_cnt increments and saturates at all-ones.
    - group_err is set.
    - first_err_idx <= vec_cnt, only if group_err was previously 0.
  - vec_cnt increments.
- Handshake rules:
  - in_data is sampled only on an accept.
  - in_valid without in_ready has no effect.
  - Back-to-back accepts are allowed at one word per cycle.
- Reset mid-run: the state returns to IDLE and all outputs return to their reset values on the next edge. A partial signature is discarded.
- Reset has priority over start.

Optional Feature:
- Macro: COLLECTOR_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in RUN and clears on every accept.
  - When it reaches TIMEOUT_CYC-1 without an accept, the next edge enters DONE and sets timeout=1.
  - sig_out and the counters hold their partial values.
- Undefined:
  - No watchdog logic is built; timeout is constant 0.
  - RUN waits indefinitely.

Test Plan:
- Reset, then start with num_vectors=1 and accept in_data=18'h00000 -> after one cycle, done=1 and sig_out=32'hFB3EE249; mismatch_cnt=0, group_err=0.
- Start with num_vectors=3 and accept three words 18'h3FFFF, 18'h0687F, 18'h39780 -> all consistent; done=1 after the third accept; mismatch_cnt=0; sig_out matches the reference model.
- Start with num_vectors=4; words 0, 18'h00001, 0, 18'h00080 -> mismatch_cnt=2, group_err=1, first_err_idx=1.
- Start with num_vectors=0 -> DONE on the next cycle, sig_out=32'hFFFFFFFF, in_ready never asserted. Separately, assert start during RUN -> ignored.
- Start with num_vectors=5; accept 2 words, assert rst -> IDLE next cycle with all outputs at reset values. Then start a fresh run and confirm the counters begin at 0.
- With COLLECTOR_TIMEOUT_EN and TIMEOUT_CYC=16: start with num_vectors=2, accept 1 word, hold in_valid=0 -> timeout=1 and done=1 exactly 16 cycles after the accept. Without the macro, the same stimulus leaves busy=1 indefinitely and timeout stays 0.
